mux2_1: RTL and testbench

- Registered 2-to-1 data multiplexer: selects one of two WIDTH-bit operands (a or b) under control of a 1-bit select.
- Drives the choice onto a registered output one clock later.
- Generic datapath steering element used wherever two byte-wide sources share a single destination.
- Single clock domain, synchronous active-low reset.

---
 rtl/mux2_1.sv | 22 ++
 tb/tb_mux2_1.sv | 112 +++++++++++
 2 files changed

// File: rtl/mux2_1.sv
// Registered 2-to-1 datapath steering element: out takes a (sel=0) or b (sel=1)
// one clock after the inputs are sampled; synchronous active-low reset.
module mux2_1 #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  // Conditional operator (not an if/else) so an unknown sel merges a and b
  // bitwise in simulation instead of silently picking one operand.
  always_ff @(posedge clk) begin
    if (!rst_n) out <= RESET_VAL;
    else        out <= sel ? b : a;
  end

endmodule

// File: tb/tb_mux2_1.sv
// Directed vector table plus a randomized stream for the registered 2:1 mux.
module tb_mux2_1;

  localparam int W = 8;

  typedef struct {
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b, out;
  logic         sel;

  int checks = 0;
  int fails  = 0;

  mux2_1 #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: out=%h expected=%h at t=%0t", name, act, req, $time);
    end
  endtask

  initial begin
    vec_t         vecs [12];
    logic [W-1:0] prev;
    logic [W-1:0] ra, rb, exp;
    logic         rs;

    // reset with b selected, then select a / b, sel toggle, reset priority
    vecs[0]  = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 8'h3C, 8'hC3, 1'b0, 8'h3C};
    vecs[3]  = '{1'b1, 8'h3C, 8'hC3, 1'b1, 8'hC3};
    vecs[4]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF};
    vecs[6]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF};
    vecs[8]  = '{1'b0, 8'h00, 8'h7E, 1'b1, 8'h00};
    vecs[9]  = '{1'b1, 8'h00, 8'h7E, 1'b1, 8'h7E};
    vecs[10] = '{1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF};
    vecs[11] = '{1'b1, 8'h5A, 8'hA5, 1'b0, 8'h5A};

    prev = 8'h00;
    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].rst_n;
      a     = vecs[i].a;
      b     = vecs[i].b;
      sel   = vecs[i].sel;
      #2;
      // before the capturing edge, out must still hold the previous result
      if (i > 0) check($sformatf("vec%0d_pre_edge", i), out, prev);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), out, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Randomized stream: junk driven early in each cycle must not leak into out
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("rnd%0d_hold", n), out, prev);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (n == 3)  ra = 8'h00;
      if (n == 5)  rb = 8'hFF;
      if (n == 8)  begin ra = 8'hFF; rb = 8'h00; end
      if (n == 11) begin ra = 8'h00; rb = 8'hFF; end
      a   = ra;
      b   = rb;
      sel = rs;
      exp = rs ? rb : ra;
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d", n), out, exp);
      prev = exp;
    end

    // Holding inputs steady keeps out steady across several edges
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d", k), out, prev);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
